uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Buffered UART transmit path: accepts bytes on a single-cycle write strobe, queues them in an internal FIFO, and serialises them on RsTx as 8N1 frames at a fixed baud rate. It is the outbound counterpart to the receive/echo path. Application logic such as a game or text engine pushes response strings here without tracking transmitter busy state. Bit timing comes from an internal divider on clk; no external baud tick is used.

## Interface
- CLK_FREQ, 100_000_000, clk frequency in Hz
- BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD (integer division), required DIV >= 2
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- data_in  input  8  byte to queue
- we  input  1  write strobe; one byte per cycle where high
- RsTx  output  1  serial line, idle high
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
- empty  output  1  FIFO holds 0 bytes
- busy  output  1  transmitter FSM not in IDLE
- overflow  output  1  sticky: a write arrived while full

## Operation
- Reset values: RsTx=1, full=0, empty=1, busy=0, overflow=0, FIFO pointers/count=0, FSM=IDLE, baud counter=0.
- FIFO: circular buffer, write/read pointers DEPTH_LOG2 bits wide, wrap modulo depth; count is DEPTH_LOG2+1 bits.
- Push when we=1 and full=0. Push when full=1 drops the byte and sets overflow. overflow clears only on reset.
- full and empty are registered and reflect count after the current edge. A simultaneous push and pop with full=1 still drops the push. Pop is impossible while empty, so push with empty=1 is a plain push.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: RsTx=1. If empty=0, pop the head into the shift register, clear the bit index, clear the baud counter, and go to START.
  - START: RsTx=0 for DIV clocks, then go to DATA.
  - DATA: RsTx=shift[0] for DIV clocks per bit, LSB first, shifting right after each bit. After bit index 7, go to STOP.
  - STOP: RsTx=1 for DIV clocks, then go to IDLE.
- Baud counter: runs 0..DIV-1 in START/DATA/STOP and wraps at DIV-1. The state or bit advances on the wrap.
- RsTx is driven from a register (glitch-free).
- Reset mid-frame: RsTx goes to 1 asynchronously, the frame is aborted, and FIFO contents are discarded.

## Timing
- Write latency: a byte pushed at edge N into an empty FIFO with FSM=IDLE is popped at edge N+1. RsTx falls at edge N+2.
- Frame length: exactly 10*DIV clocks from the RsTx falling edge to the end of the stop bit.
- Back-to-back frames: one extra IDLE clock (RsTx=1) between the stop bit and the next start bit. Frame period = 10*DIV+1 clocks.
- busy is high from the pop edge through the last stop-bit clock.
- Throughput limit: sustained we above 1 byte per (10*DIV+1) clocks fills the FIFO, after which overflow is set.

## Configuration
- UART_TX_PRINTABLE_FILTER_EN defined: a write is accepted only if data_in is in 0x20..0x7E or equals 0x0A or 0x0D. Other bytes are silently ignored: no push, no overflow, no flag change.
- Undefined: every byte 0x00..0xFF is accepted subject to full.

## Test plan
All scenarios use CLK_FREQ=1000, BAUD=100 (DIV=10), DEPTH_LOG2=2.
- Single byte 0x41 written to an idle block -> RsTx low 2 clocks after the write. Line shows bits 1,0,0,0,0,0,1,0 (LSB first), each 10 clocks wide, then 10 high clocks. busy drops and empty=1.
- Five consecutive-cycle writes 0x30..0x34 -> first byte popped immediately, then 4 queued. full=1 after the fifth write; overflow=0. Five frames are sent in order, 101 clocks apart.
- A sixth write while full, 0x35 -> dropped and overflow=1. The transmitted sequence excludes 0x35. overflow stays 1 after the FIFO drains.
- reset asserted at clock 35 of a frame -> RsTx=1 asynchronously. empty=1, busy=0, overflow=0, and no further frames are sent.
- Filter enabled: write 0x07, then 0x41, then 0x0D -> only 0x41 and 0x0D are transmitted and overflow=0. Filter disabled: all three are transmitted.
- Write 0x55 on the same edge the FSM returns to IDLE with the FIFO empty -> popped on the next edge, with start bit 2 clocks after the write. The line shows an alternating 1,0,1,0,1,0,1,0 pattern.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: buffered 8N1 UART transmitter.
// Bytes written on a single-cycle strobe are queued in a circular FIFO. A
// small FSM pops them one at a time and serialises each one on RsTx, LSB first.
// Bit timing comes from an internal divider, DIV = CLK_FREQ / BAUD, which
// must be at least 2.
//
// Optional feature: define UART_TX_PRINTABLE_FILTER_EN to accept only the
// printable bytes 0x20..0x7E plus LF (0x0A) and CR (0x0D). All other bytes are
// ignored without any side effect.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high; clears all state
//   data_in   in   [7:0] byte to queue
//   we        in   write strobe, one byte per cycle while high
//   RsTx      out  serial line, idle high, registered
//   full      out  FIFO holds 2**DEPTH_LOG2 bytes
//   empty     out  FIFO holds 0 bytes
//   busy      out  transmitter FSM is not in IDLE
//   overflow  out  sticky: a write arrived while full
module uart_tx_buffer #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       we,
    output logic       RsTx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DIV     = CLK_FREQ / BAUD;
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W   = DEPTH_LOG2;
    localparam int unsigned FCNT_W  = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                rstx_q, rstx_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          mem_q [DEPTH];

    logic                accept_c;
    logic                push_c;
    logic                pop_c;
    logic                baud_wrap_c;

    // Which bytes are eligible for queueing at all.
`ifdef UART_TX_PRINTABLE_FILTER_EN
    assign accept_c = ((data_in >= 8'h20) && (data_in <= 8'h7E)) ||
                      (data_in == 8'h0A) || (data_in == 8'h0D);
`else
    assign accept_c = 1'b1;
`endif

    // A write while full is dropped, even if a pop happens on the same edge.
    assign push_c      = we & accept_c & ~full_q;
    assign baud_wrap_c = (baud_q == CNT_W'(DIV - 1));

    // Transmit FSM: next state, baud/bit counters, shift register, line level.
    // The line register follows state_q, so RsTx lags the FSM by one clock.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rstx_d    = 1'b1;
        pop_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                rstx_d = 1'b1;
                if (!empty_q) begin
                    pop_c     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    baud_d    = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                rstx_d = 1'b0;
                baud_d = baud_wrap_c ? '0 : baud_q + CNT_W'(1);
                if (baud_wrap_c) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                rstx_d = shift_q[0];
                baud_d = baud_wrap_c ? '0 : baud_q + CNT_W'(1);
                if (baud_wrap_c) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                rstx_d = 1'b1;
                baud_d = baud_wrap_c ? '0 : baud_q + CNT_W'(1);
                if (baud_wrap_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; flags reflect the count after the current edge.
    always_comb begin
        wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (we & accept_c & full_q);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FCNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // FIFO storage; contents become unreachable when the pointers reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rstx_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rstx_q     <= rstx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign RsTx     = rstx_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer with CLK_FREQ=1000, BAUD=100 (DIV=10) and a
// 4-entry FIFO. A line monitor records every frame as 100 samples, decodes
// the byte, and notes the clock of its start bit and whether every bit was
// exactly 10 clocks wide.
module tb_uart_tx_buffer;

    localparam int unsigned CLK_FREQ   = 1000;
    localparam int unsigned BAUD       = 100;
    localparam int unsigned DEPTH_LOG2 = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       we = 1'b0;
    logic       RsTx;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] rx_bytes [$];
    int         rx_start [$];
    logic       rx_ok    [$];

    uart_tx_buffer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .we       (we),
        .RsTx     (RsTx),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow)
    );

    initial forever #5 clk = ~clk;

    // Counts rising edges; read only at #1 after an edge or at a falling edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line monitor: sampled on the falling edge, frames abandoned on reset.
    initial begin
        int          mon_idx;
        int          mon_start;
        logic [99:0] mon_bits;
        logic [7:0]  b;
        logic        ok;
        mon_idx = -1;
        mon_start = 0;
        mon_bits = '1;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_idx = -1;
            end else if (mon_idx < 0) begin
                if (RsTx === 1'b0) begin
                    mon_bits    = '1;
                    mon_bits[0] = 1'b0;
                    mon_idx     = 1;
                    mon_start   = cyc;
                end
            end else begin
                mon_bits[mon_idx] = RsTx;
                if (mon_idx == 99) begin
                    ok = 1'b1;
                    for (int g = 0; g < 10; g++) begin
                        for (int k = 0; k < 10; k++) begin
                            if (mon_bits[g*10+k] !== mon_bits[g*10]) ok = 1'b0;
                        end
                    end
                    if (mon_bits[0] !== 1'b0 || mon_bits[90] !== 1'b1) ok = 1'b0;
                    for (int i = 0; i < 8; i++) b[i] = mon_bits[(i+1)*10];
                    rx_bytes.push_back(b);
                    rx_start.push_back(mon_start);
                    rx_ok.push_back(ok);
                    mon_idx = -1;
                end else begin
                    mon_idx++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds we for exactly one rising edge; wc is the count of that edge.
    task automatic write_byte(input logic [7:0] b, output int wc);
        data_in = b;
        we = 1'b1;
        @(posedge clk);
        #1;
        wc = cyc;
        we = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_frames(input int n, input int budget, output logic done);
        int k;
        k = 0;
        while (rx_bytes.size() < n && k < budget) begin
            tick();
            k++;
        end
        done = (rx_bytes.size() >= n);
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_start.delete();
        rx_ok.delete();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (RsTx !== 1'b1)     begin n_err++; $display("FAIL reset_rstx: got %b want 1", RsTx); end
        n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b0;
        repeat (5) tick();
        n_cmp++; if (RsTx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1)
            begin n_err++; $display("FAIL idle_after_reset: got rstx=%b busy=%b empty=%b want 1 0 1", RsTx, busy, empty); end
    endtask

    task automatic test_single_byte();
        int   wc;
        logic done;
        clear_rx();
        write_byte(8'h41, wc);
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty_push: got %b want 0", empty); end
        tick();
        n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL single_busy_pop: got %b want 1", busy); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_pop: got %b want 1", empty); end
        wait_frames(1, 200, done);
        n_cmp++; if (done !== 1'b1)  begin n_err++; $display("FAIL single_timeout: got %0d frames want 1", rx_bytes.size()); end
        if (rx_bytes.size() > 0) begin
            n_cmp++; if (rx_bytes[0] !== 8'h41) begin n_err++; $display("FAIL single_byte: got %h want 41", rx_bytes[0]); end
            n_cmp++; if (rx_ok[0] !== 1'b1)     begin n_err++; $display("FAIL single_framing: got %b want 1", rx_ok[0]); end
            n_cmp++; if (rx_start[0] - wc != 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", rx_start[0] - wc); end
        end
        wait_until(wc + 103);
        n_cmp++; if (busy !== 1'b0 || empty !== 1'b1 || RsTx !== 1'b1)
            begin n_err++; $display("FAIL single_done: got busy=%b empty=%b rstx=%b want 0 1 1", busy, empty, RsTx); end
    endtask

    task automatic test_burst_overflow();
        int   w0;
        int   wc;
        logic done;
        clear_rx();
        write_byte(8'h30, w0);
        write_byte(8'h31, wc);
        write_byte(8'h32, wc);
        write_byte(8'h33, wc);
        write_byte(8'h34, wc);
        n_cmp++; if (full !== 1'b1)     begin n_err++; $display("FAIL burst_full: got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_no_overflow: got %b want 0", overflow); end
        write_byte(8'h35, wc);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        n_cmp++; if (full !== 1'b1)     begin n_err++; $display("FAIL burst_still_full: got %b want 1", full); end
        wait_frames(5, 700, done);
        n_cmp++; if (done !== 1'b1)     begin n_err++; $display("FAIL burst_timeout: got %0d frames want 5", rx_bytes.size()); end
        repeat (150) tick();
        n_cmp++; if (rx_bytes.size() != 5) begin n_err++; $display("FAIL burst_count: got %0d want 5", rx_bytes.size()); end
        for (int i = 0; i < 5 && i < rx_bytes.size(); i++) begin
            n_cmp++; if (rx_bytes[i] !== 8'(8'h30 + i))
                begin n_err++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_bytes[i], 8'(8'h30 + i)); end
            n_cmp++; if (rx_ok[i] !== 1'b1)
                begin n_err++; $display("FAIL burst_framing%0d: got %b want 1", i, rx_ok[i]); end
            if (i > 0) begin
                n_cmp++; if (rx_start[i] - rx_start[i-1] != 101)
                    begin n_err++; $display("FAIL burst_period%0d: got %0d want 101", i, rx_start[i] - rx_start[i-1]); end
            end
        end
        if (rx_start.size() > 0) begin
            n_cmp++; if (rx_start[0] - w0 != 2) begin n_err++; $display("FAIL burst_latency: got %0d want 2", rx_start[0] - w0); end
        end
        n_cmp++; if (empty !== 1'b1 || overflow !== 1'b1)
            begin n_err++; $display("FAIL burst_drained: got empty=%b overflow=%b want 1 1", empty, overflow); end
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        int wc;
        clear_rx();
        write_byte(8'h41, w0);
        write_byte(8'h42, wc);
        // Frame clock 0 follows edge w0+2, so clock 35 (data bit 2 = 0) follows w0+37.
        wait_until(w0 + 37);
        #3;
        n_cmp++; if (RsTx !== 1'b0) begin n_err++; $display("FAIL midreset_pre_rstx: got %b want 0", RsTx); end
        reset = 1'b1;
        #1;
        n_cmp++; if (RsTx !== 1'b1)     begin n_err++; $display("FAIL midreset_rstx: got %b want 1", RsTx); end
        n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL midreset_empty: got %b want 1", empty); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midreset_overflow: got %b want 0", overflow); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (300) tick();
        n_cmp++; if (rx_bytes.size() != 0) begin n_err++; $display("FAIL midreset_frames: got %0d want 0", rx_bytes.size()); end
        n_cmp++; if (RsTx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0)
            begin n_err++; $display("FAIL midreset_idle: got rstx=%b empty=%b busy=%b want 1 1 0", RsTx, empty, busy); end
    endtask

    task automatic test_filter();
        int         w0;
        int         wc;
        int         n_exp;
        logic       done;
        logic [7:0] exp_bytes [3];
`ifdef UART_TX_PRINTABLE_FILTER_EN
        n_exp = 2;
        exp_bytes[0] = 8'h41;
        exp_bytes[1] = 8'h0D;
        exp_bytes[2] = 8'h00;
`else
        n_exp = 3;
        exp_bytes[0] = 8'h07;
        exp_bytes[1] = 8'h41;
        exp_bytes[2] = 8'h0D;
`endif
        clear_rx();
        write_byte(8'h07, w0);
        write_byte(8'h41, wc);
        write_byte(8'h0D, wc);
        wait_frames(n_exp, 450, done);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL filter_timeout: got %0d frames want %0d", rx_bytes.size(), n_exp); end
        repeat (150) tick();
        n_cmp++; if (rx_bytes.size() != n_exp) begin n_err++; $display("FAIL filter_count: got %0d want %0d", rx_bytes.size(), n_exp); end
        for (int i = 0; i < n_exp && i < rx_bytes.size(); i++) begin
            n_cmp++; if (rx_bytes[i] !== exp_bytes[i])
                begin n_err++; $display("FAIL filter_byte%0d: got %h want %h", i, rx_bytes[i], exp_bytes[i]); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL filter_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_write_on_idle_return();
        int   w0;
        int   wc;
        logic done;
        clear_rx();
        write_byte(8'h5A, w0);
        // Popped at w0+1, so the FSM re-enters IDLE on edge w0+101.
        wait_until(w0 + 100);
        write_byte(8'h55, wc);
        n_cmp++; if (busy !== 1'b0 || empty !== 1'b0)
            begin n_err++; $display("FAIL edge_write: got busy=%b empty=%b want 0 0", busy, empty); end
        tick();
        n_cmp++; if (busy !== 1'b1 || empty !== 1'b1)
            begin n_err++; $display("FAIL edge_pop: got busy=%b empty=%b want 1 1", busy, empty); end
        wait_frames(2, 250, done);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL edge_timeout: got %0d frames want 2", rx_bytes.size()); end
        if (rx_bytes.size() >= 2) begin
            n_cmp++; if (rx_bytes[0] !== 8'h5A) begin n_err++; $display("FAIL edge_first: got %h want 5a", rx_bytes[0]); end
            n_cmp++; if (rx_bytes[1] !== 8'h55) begin n_err++; $display("FAIL edge_second: got %h want 55", rx_bytes[1]); end
            n_cmp++; if (rx_ok[1] !== 1'b1)     begin n_err++; $display("FAIL edge_framing: got %b want 1", rx_ok[1]); end
            n_cmp++; if (rx_start[1] - wc != 2) begin n_err++; $display("FAIL edge_latency: got %0d want 2", rx_start[1] - wc); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_reset_mid_frame();
        test_filter();
        test_write_on_idle_return();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
